// File: rtl/pcs_slip_ctrl.sv
// PCS gearbox bit-slip controller: advances the block alignment offset on each
// slip request, blanks header validity while the gearbox settles, and flags a full sweep without lock.
module pcs_slip_ctrl #(
    parameter int unsigned HEAD_W     = 2,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal_ok_i,
    input  logic       slip_req_i,
    input  logic       lock_i,
    output logic [6:0] offset_o,
    output logic       offset_upd_o,
    output logic       valid_o,
    output logic       slip_done_o,
    output logic       sweep_fail_o
);

    localparam int unsigned BLOCK_W = HEAD_W + DATA_W;
    localparam int unsigned OFF_W   = 7;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned SET_W   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [OFF_W-1:0] offset_n;
    logic [CNT_W-1:0] slip_cnt;
    logic [CNT_W-1:0] slip_cnt_n;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_cnt_n;

    // Next-state and next-value logic; signal loss overrides every transition.
    always_comb begin
        state_n      = state;
        offset_n     = offset_o;
        slip_cnt_n   = slip_cnt;
        settle_cnt_n = settle_cnt;
        if (!signal_ok_i) begin
            state_n    = ST_IDLE;
            slip_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n    = ST_RUN;
                    slip_cnt_n = '0;
                end
                ST_RUN: begin
                    if (slip_req_i) begin
                        state_n    = ST_SHIFT;
                        offset_n   = (offset_o == OFF_W'(BLOCK_W - 1)) ? '0 : offset_o + OFF_W'(1);
                        slip_cnt_n = slip_cnt + CNT_W'(1);
                    end else if (lock_i) begin
                        slip_cnt_n = '0;
                    end
                end
                ST_SHIFT: begin
                    state_n      = ST_SETTLE;
                    settle_cnt_n = SET_W'(SETTLE_CYC - 1);
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        settle_cnt_n = settle_cnt - SET_W'(1);
                    end
                end
                ST_DONE: begin
                    state_n = ST_RUN;
                    if (slip_cnt == CNT_W'(BLOCK_W)) begin
                        slip_cnt_n = '0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered decodes of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            offset_o     <= '0;
            slip_cnt     <= '0;
            settle_cnt   <= '0;
            valid_o      <= 1'b0;
            offset_upd_o <= 1'b0;
            slip_done_o  <= 1'b0;
            sweep_fail_o <= 1'b0;
        end else begin
            state        <= state_n;
            offset_o     <= offset_n;
            slip_cnt     <= slip_cnt_n;
            settle_cnt   <= settle_cnt_n;
            valid_o      <= (state_n == ST_RUN);
            offset_upd_o <= (state_n == ST_SHIFT);
            slip_done_o  <= (state_n == ST_DONE);
            sweep_fail_o <= (state_n == ST_DONE) && (slip_cnt_n == CNT_W'(BLOCK_W));
        end
    end

endmodule

// File: tb/tb_pcs_slip_ctrl.sv
// Directed bench for pcs_slip_ctrl: single slips, ignored requests, full sweeps,
// lock interaction, signal loss and reset during a slip.
module tb_pcs_slip_ctrl;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned BLK    = 66;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal_ok;
    logic       slip_req;
    logic       lock;
    logic [6:0] offset;
    logic       offset_upd;
    logic       valid;
    logic       slip_done;
    logic       sweep_fail;

    int total  = 0;
    int passed = 0;
    int exp_off = 0;
    int done_seen;

    pcs_slip_ctrl #(
        .HEAD_W    (2),
        .DATA_W    (64),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .signal_ok_i (signal_ok),
        .slip_req_i  (slip_req),
        .lock_i      (lock),
        .offset_o    (offset),
        .offset_upd_o(offset_upd),
        .valid_o     (valid),
        .slip_done_o (slip_done),
        .sweep_fail_o(sweep_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse a slip from RUN and check every cycle through the return to RUN.
    task automatic do_slip(input logic lk, input logic exp_sw);
        slip_req = 1'b1;
        lock     = lk;
        step();
        slip_req = 1'b0;
        lock     = 1'b0;
        exp_off  = (exp_off == int'(BLK) - 1) ? 0 : exp_off + 1;
        chk("shift_offset", int'(offset), exp_off);
        chk("shift_upd", int'(offset_upd), 1);
        chk("shift_valid", int'(valid), 0);
        for (int i = 0; i < int'(SETTLE); i++) begin
            step();
            chk("settle_upd", int'(offset_upd), 0);
            chk("settle_valid", int'(valid), 0);
            chk("settle_done", int'(slip_done), 0);
        end
        step();
        chk("done_pulse", int'(slip_done), 1);
        chk("done_valid", int'(valid), 0);
        chk("done_sweep", int'(sweep_fail), int'(exp_sw));
        step();
        chk("run_valid", int'(valid), 1);
        chk("run_done", int'(slip_done), 0);
        chk("run_sweep", int'(sweep_fail), 0);
        chk("run_offset", int'(offset), exp_off);
    endtask

    initial begin
        reset     = 1'b1;
        signal_ok = 1'b0;
        slip_req  = 1'b0;
        lock      = 1'b0;
        step();
        step();
        chk("rst_offset", int'(offset), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_pulses", int'({offset_upd, slip_done, sweep_fail}), 0);

        // Bring-up and idle running with no slips.
        reset     = 1'b0;
        signal_ok = 1'b1;
        step();
        chk("bringup_valid", int'(valid), 1);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_run", int'({valid, offset_upd, slip_done, sweep_fail, offset}), 32'h400);
        end

        // Single slip with full latency check.
        do_slip(1'b0, 1'b0);

        // Requests during SHIFT/SETTLE/DONE are dropped.
        done_seen = 0;
        slip_req  = 1'b1;
        step();
        chk("ign_shift_offset", int'(offset), 2);
        for (int i = 0; i < int'(SETTLE) + 1; i++) begin
            step();
            done_seen += int'(slip_done);
        end
        slip_req = 1'b0;
        step();
        chk("ign_done_count", done_seen, 1);
        chk("ign_offset", int'(offset), 2);
        chk("ign_valid", int'(valid), 1);
        step();
        chk("ign_no_extra_upd", int'(offset_upd), 0);
        exp_off = 2;

        // Fresh start so the sweep begins at offset 0.
        reset = 1'b1;
        step();
        chk("rst2_offset", int'(offset), 0);
        chk("rst2_valid", int'(valid), 0);
        reset = 1'b0;
        step();
        chk("rst2_run", int'(valid), 1);
        exp_off = 0;

        // Two full sweeps back to back: the counter must re-arm after the first.
        for (int k = 1; k <= 2 * int'(BLK); k++) begin
            do_slip(1'b0, (k == int'(BLK)) || (k == 2 * int'(BLK)));
        end
        chk("sweep_wrap_offset", int'(offset), 0);

        // Partial sweep, then lock clears the count.
        for (int k = 1; k <= 30; k++) do_slip(1'b0, 1'b0);
        lock = 1'b1;
        step();
        lock = 1'b0;
        chk("lock_valid", int'(valid), 1);
        // First post-lock slip arrives with lock still high: slip must win.
        for (int k = 1; k <= int'(BLK); k++) begin
            do_slip(k == 1, k == int'(BLK));
        end

        // Signal loss during SETTLE aborts the slip but keeps the offset.
        slip_req = 1'b1;
        step();
        slip_req = 1'b0;
        exp_off  = (exp_off == int'(BLK) - 1) ? 0 : exp_off + 1;
        step();
        signal_ok = 1'b0;
        step();
        chk("los_valid", int'(valid), 0);
        chk("los_done", int'(slip_done), 0);
        chk("los_offset", int'(offset), exp_off);
        slip_req = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            done_seen += int'(slip_done) + int'(offset_upd) + int'(valid);
        end
        slip_req = 1'b0;
        chk("los_idle_quiet", done_seen, 0);
        chk("los_idle_offset", int'(offset), exp_off);
        signal_ok = 1'b1;
        step();
        chk("los_restore_valid", int'(valid), 1);
        chk("los_restore_offset", int'(offset), exp_off);

        // Reset in the middle of a slip clears the offset and suppresses done.
        slip_req = 1'b1;
        step();
        slip_req = 1'b0;
        chk("mid_upd", int'(offset_upd), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_offset", int'(offset), 0);
        chk("mid_rst_valid", int'(valid), 0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            done_seen += int'(slip_done) + int'(offset_upd);
        end
        chk("mid_no_done", done_seen, 0);
        chk("mid_valid", int'(valid), 1);
        chk("mid_offset", int'(offset), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pcs_slip_ctrl.md
PCS_SLIP_CTRL -- requirements
Module: pcs_slip_ctrl

Interface
REQ-001 SHALL provide parameter HEAD_W, default 2, sync header width in bits.
REQ-002 SHALL provide parameter DATA_W, default 64, block payload width in bits; BLOCK_W = HEAD_W + DATA_W (66).
REQ-003 SHALL provide parameter SETTLE_CYC, default 2, range 1..15, blanking cycles after each offset change.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port signal_ok_i  in  1  PMA signal present.
REQ-007 SHALL have port slip_req_i  in  1  slip request from block-lock FSM, single-cycle pulse.
REQ-008 SHALL have port lock_i  in  1  rx_block_lock from block-lock FSM.
REQ-009 SHALL have port offset_o  out  7  gearbox bit alignment offset, 0..BLOCK_W-1.
REQ-010 SHALL have port offset_upd_o  out  1  one-cycle pulse, offset_o changed this cycle.
REQ-011 SHALL have port valid_o  out  1  header valid to block-lock FSM (its valid_i).
REQ-012 SHALL have port slip_done_o  out  1  one-cycle pulse, slip complete.
REQ-013 SHALL have port sweep_fail_o  out  1  one-cycle pulse, BLOCK_W slips without lock.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, SHIFT, SETTLE, DONE.
REQ-015 IDLE: valid_o=0; signal_ok_i=1 -> RUN next cycle.
REQ-016 RUN: valid_o=1; slip_req_i=1 -> SHIFT next cycle, else stay.
REQ-017 On RUN->SHIFT edge: offset_o <= offset_o+1, wrapping BLOCK_W-1 -> 0; offset_upd_o=1 for the SHIFT cycle only.
REQ-018 SHIFT: valid_o=0; -> SETTLE next cycle; settle counter loaded with SETTLE_CYC-1.
REQ-019 SETTLE: valid_o=0; counter decrements each cycle; at 0 -> DONE; SETTLE lasts exactly SETTLE_CYC cycles.
REQ-020 DONE: slip_done_o=1, valid_o=0, exactly one cycle; -> RUN.
REQ-021 Latency: slip_req_i high in cycle n (RUN) -> offset_upd_o at n+1, slip_done_o at n+2+SETTLE_CYC, valid_o=1 again at n+3+SETTLE_CYC.
REQ-022 slip_req_i in IDLE, SHIFT, SETTLE or DONE SHALL be ignored, not queued.
REQ-023 signal_ok_i=0 in any state SHALL force IDLE next cycle, take priority over all other transitions, and suppress any pending slip_done_o; offset_o retained.
REQ-024 Slip counter (7 bits) SHALL increment on each RUN->SHIFT transition.
REQ-025 Slip counter SHALL clear when lock_i=1 in RUN with slip_req_i=0, and on entry to IDLE.
REQ-026 lock_i=1 and slip_req_i=1 in same RUN cycle: slip wins, counter increments.
REQ-027 If counter equals BLOCK_W in DONE, sweep_fail_o=1 that cycle and counter clears to 0 on the next edge.
REQ-028 All outputs SHALL be glitch-free functions of registered state; no combinational path from inputs to outputs.
REQ-029 offset_upd_o, slip_done_o, sweep_fail_o SHALL never be high for two consecutive cycles.

Reset
REQ-030 reset=1 SHALL force, next edge: state IDLE, offset_o=0, slip counter 0, settle counter 0.
REQ-031 During and after reset until IDLE exits: valid_o=0, offset_upd_o=0, slip_done_o=0, sweep_fail_o=0.
REQ-032 reset asserted mid-slip (SHIFT/SETTLE/DONE) SHALL abort the slip without slip_done_o and clear offset_o to 0.

Verification
REQ-033 Reset, signal_ok_i=1, no slips for 100 cycles -> valid_o=1 from cycle 2 onward, offset_o=0, no pulses.
REQ-034 SETTLE_CYC=2, slip_req_i pulse at cycle n -> offset_o 0->1 and offset_upd_o at n+1, valid_o=0 n+1..n+4, slip_done_o at n+4, valid_o=1 at n+5.
REQ-035 66 back-to-back slips with lock_i=0 -> offset_o wraps 65->0 on 66th slip, sweep_fail_o pulses once in 66th DONE, counter returns to 0.
REQ-036 30 slips, lock_i=1 one RUN cycle, 66 more slips -> sweep_fail_o only on the 66th post-lock slip.
REQ-037 slip_req_i pulsed in SHIFT and SETTLE cycles -> ignored; exactly one offset increment and one slip_done_o.
REQ-038 signal_ok_i dropped in SETTLE -> IDLE next cycle, no slip_done_o, offset_o retained; signal_ok_i restored -> RUN, valid_o=1.
